csa_accumulator: RTL and testbench

- Parametrised multi-operand accumulator built on the full-adder/half-adder cell mapping.
- Adds one operand per cycle into a redundant carry-save (sum S, carry C) state, so there is no carry propagation in the accumulate path.
- On request, resolves S+C to binary with a chunked carry-propagate adder over several cycles, then presents the result on a valid/ready output.
- Sits in datapath blocks such as MAC, checksum and counter reductions, where long accumulate runs dominate and resolves are rare.

---
 rtl/csa_accumulator.sv | 160 ++++++++++++++++
 tb/tb_csa_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator. Operands fold into a redundant (S, C)
// pair with no carry propagation; on request the pair is resolved to binary
// one CHUNK per cycle and offered on a valid/ready output.

// One bit of the 3:2 compressor. The carry into bit i comes from the
// majority of bit i-1, so the top bit's carry-out is never formed.
module csa_bit (
  input  logic a,
  input  logic b,
  input  logic x,
  input  logic a_lo,
  input  logic b_lo,
  input  logic x_lo,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ x;
  assign c = (a_lo & b_lo) | (a_lo & x_lo) | (b_lo & x_lo);
endmodule

module csa_accumulator #(
  parameter int WIDTH      = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CHUNK      = 8,
  parameter int COUNT_W    = 16,
  parameter int AUTO_CLEAR = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  input  logic                 resolve_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [COUNT_W-1:0]   out_count,
  output logic                 busy
);
  localparam int NCHUNK = ACC_WIDTH / CHUNK;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  s_q, c_q, res_q, sum_q;
  logic [COUNT_W-1:0]    cnt_q;
  logic [CIDX_W-1:0]     idx_q;
  logic                  carry_q;

  logic [ACC_WIDTH-1:0]  s_base, c_base, x_ext, s_csa, c_csa, res_d;
  logic [COUNT_W-1:0]    cnt_base, cnt_inc;
  logic [CHUNK-1:0]      ch_sum;
  logic                  cy_d, accept, last_chunk;
  int                    base;

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == OUTPUT);
  assign busy       = (state_q != ACCUM);
  assign out_sum    = sum_q;
  assign out_count  = cnt_q;
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx_q == CIDX_W'(NCHUNK - 1));

  // Clear is applied ahead of any same-cycle operand, so the compressor
  // sees a zeroed state when both arrive together.
  always_comb begin
    x_ext            = '0;
    x_ext[WIDTH-1:0] = in_data;
    s_base           = clear ? '0 : s_q;
    c_base           = clear ? '0 : c_q;
    cnt_base         = clear ? '0 : cnt_q;
    cnt_inc          = (cnt_base == {COUNT_W{1'b1}}) ? cnt_base : cnt_base + 1'b1;
  end

  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_csa
    if (i == 0) begin : g_lsb
      csa_bit u_bit (.a(s_base[0]), .b(c_base[0]), .x(x_ext[0]),
                     .a_lo(1'b0), .b_lo(1'b0), .x_lo(1'b0),
                     .s(s_csa[0]), .c(c_csa[0]));
    end else begin : g_bit
      csa_bit u_bit (.a(s_base[i]), .b(c_base[i]), .x(x_ext[i]),
                     .a_lo(s_base[i-1]), .b_lo(c_base[i-1]), .x_lo(x_ext[i-1]),
                     .s(s_csa[i]), .c(c_csa[i]));
    end
  end

  // Chunked carry-propagate: resolve one CHUNK of S+C per cycle, LSB first.
  always_comb begin
    base                = int'(idx_q) * CHUNK;
    {cy_d, ch_sum}      = {1'b0, s_q[base +: CHUNK]} + {1'b0, c_q[base +: CHUNK]}
                        + {{CHUNK{1'b0}}, carry_q};
    res_d               = res_q;
    res_d[base +: CHUNK] = ch_sum;
  end

  // Next-state selection; control inputs only matter in ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (resolve_req) state_d = RESOLVE;
      RESOLVE: if (last_chunk)  state_d = OUTPUT;
      OUTPUT:  if (out_ready)   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State register plus accumulator, resolver and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ACCUM: begin
          if (clear || accept) begin
            s_q   <= accept ? s_csa : '0;
            c_q   <= accept ? c_csa : '0;
            cnt_q <= accept ? cnt_inc : '0;
          end
          if (resolve_req) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        RESOLVE: begin
          res_q   <= res_d;
          carry_q <= cy_d;
          idx_q   <= idx_q + CIDX_W'(1);
          // Publish only the finished sum so out_sum never shows partials.
          if (last_chunk) begin
            sum_q <= res_d;
            idx_q <= '0;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (AUTO_CLEAR != 0) begin
              s_q   <= '0;
              c_q   <= '0;
              cnt_q <= '0;
            end else begin
              s_q <= sum_q;
              c_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: one auto-clearing and one retaining instance
// share the same stimulus; a reference adder model feeds a result queue.
module tb_csa_accumulator;
  localparam int W = 32, AW = 40, CH = 8, CW = 16, NCH = AW / CH;

  logic clk = 1'b0;
  logic rst, in_valid, clear, resolve_req, out_ready;
  logic [W-1:0] in_data;
  logic in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [AW-1:0] out_sum0, out_sum1;
  logic [CW-1:0] out_count0, out_count1;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CHUNK(CH), .COUNT_W(CW), .AUTO_CLEAR(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .clear(clear), .resolve_req(resolve_req), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_count(out_count0), .busy(busy0));

  csa_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .CHUNK(CH), .COUNT_W(CW), .AUTO_CLEAR(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .clear(clear), .resolve_req(resolve_req), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_count(out_count1), .busy(busy1));

  typedef struct {
    logic [AW-1:0] s0; logic [CW-1:0] c0;
    logic [AW-1:0] s1; logic [CW-1:0] c1;
  } exp_t;

  typedef struct {
    int n; logic [W-1:0] val; logic [AW-1:0] sum; logic [CW-1:0] cnt;
  } vec_t;

  exp_t q[$];
  int errors = 0, checks = 0;
  logic [AW-1:0] m_acc0 = '0, m_acc1 = '0;
  logic [CW-1:0] m_cnt0 = '0, m_cnt1 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc0 = '0; m_acc1 = '0; m_cnt0 = '0; m_cnt1 = '0;
  endtask

  // One ACCUM cycle: drive inputs, advance the model, push on resolve.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic clr, input logic res);
    in_valid = v; in_data = d; clear = clr; resolve_req = res;
    if (clr) model_reset();
    if (v) begin
      m_acc0 = m_acc0 + AW'(d);
      m_acc1 = m_acc1 + AW'(d);
      if (m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
      if (m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
    end
    if (res) q.push_back('{m_acc0, m_cnt0, m_acc1, m_cnt1});
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; clear = 1'b0; resolve_req = 1'b0;
  endtask

  // Called right after the resolve_req edge: wait for out_valid, compare
  // against the queue, optionally backpressure, then handshake.
  task automatic finish_resolve(input int hold, output logic [AW-1:0] g_s0, output logic [CW-1:0] g_c0,
                                output logic [AW-1:0] g_s1, output logic [CW-1:0] g_c1);
    int n = 1;
    exp_t e;
    while (!out_valid0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), 64'(NCH + 1));
    g_s0 = out_sum0; g_c0 = out_count0; g_s1 = out_sum1; g_c1 = out_count1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected entry");
      e = '{'0, '0, '0, '0};
    end else e = q.pop_front();
    chk("sum0", 64'(out_sum0), 64'(e.s0));
    chk("count0", 64'(out_count0), 64'(e.c0));
    chk("sum1", 64'(out_sum1), 64'(e.s1));
    chk("count1", 64'(out_count1), 64'(e.c1));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 32'd55; clear = 1'b1; resolve_req = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid0), 64'd1);
      chk("hold_sum", 64'(out_sum0), 64'(e.s0));
      chk("hold_ready", 64'(in_ready0), 64'd0);
    end
    in_valid = 1'b0; in_data = '0; clear = 1'b0; resolve_req = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", 64'(out_valid0), 64'd0);
    chk("post_in_ready", 64'(in_ready0), 64'd1);
    chk("post_busy", 64'(busy0), 64'd0);
    m_acc0 = '0; m_cnt0 = '0;
  endtask

  initial begin
    vec_t tab[5];
    logic [AW-1:0] s0, s1;
    logic [CW-1:0] c0, c1;
    int seen;

    tab[0] = '{0,   32'h0,        40'd0,            16'd0};
    tab[1] = '{300, 32'hFFFFFFFF, 40'd188978560724, 16'd300};
    tab[2] = '{4,   32'd1000,     40'd4000,         16'd4};
    tab[3] = '{3,   32'h80000000, 40'h0180000000,   16'd3};
    tab[4] = '{1,   32'hFFFFFFFF, 40'h00FFFFFFFF,   16'd1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; resolve_req = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready0), 64'd1);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_sum", 64'(out_sum0), 64'd0);
    chk("rst_count", 64'(out_count0), 64'd0);

    // Basic accumulate, then an auto-cleared versus retained re-resolve.
    cyc(1, 5, 0, 0); cyc(1, 7, 0, 0); cyc(1, 11, 0, 0);
    chk("busy_accum", 64'(busy0), 64'd0);
    cyc(0, 0, 0, 1);
    chk("busy_resolve", 64'(busy0), 64'd1);
    finish_resolve(0, s0, c0, s1, c1);
    chk("basic_sum", 64'(s0), 64'd23);
    chk("basic_count", 64'(c0), 64'd3);
    cyc(0, 0, 0, 1);
    finish_resolve(0, s0, c0, s1, c1);
    chk("autoclr_sum0", 64'(s0), 64'd0);
    chk("retain_sum1", 64'(s1), 64'd23);
    chk("retain_count1", 64'(c1), 64'd3);

    // Table of accumulate runs, each resolved on an auto-cleared state.
    cyc(0, 0, 1, 0);
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < tab[t].n; k++) cyc(1, tab[t].val, 0, 0);
      cyc(0, 0, 0, 1);
      finish_resolve(0, s0, c0, s1, c1);
      chk($sformatf("tab%0d_sum", t), 64'(s0), 64'(tab[t].sum));
      chk($sformatf("tab%0d_count", t), 64'(c0), 64'(tab[t].cnt));
    end

    // Clear + operand + resolve in one cycle.
    cyc(1, 100, 0, 0);
    cyc(1, 9, 1, 1);
    finish_resolve(0, s0, c0, s1, c1);
    chk("same_cycle_sum", 64'(s1), 64'd9);
    chk("same_cycle_count", 64'(c1), 64'd1);

    // Backpressure for 10 cycles with all inputs toggling.
    cyc(1, 6, 0, 0);
    cyc(0, 0, 0, 1);
    finish_resolve(10, s0, c0, s1, c1);
    chk("bp_sum0", 64'(s0), 64'd6);

    // Retaining instance: 40 resolved, then +2 on top of it.
    cyc(0, 0, 1, 0);
    cyc(1, 40, 0, 0);
    cyc(0, 0, 0, 1);
    finish_resolve(0, s0, c0, s1, c1);
    cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 1);
    finish_resolve(0, s0, c0, s1, c1);
    chk("noclr_sum1", 64'(s1), 64'd42);
    chk("noclr_count1", 64'(c1), 64'd2);
    chk("noclr_sum0", 64'(s0), 64'd2);

    // Reset while the third chunk is being resolved.
    cyc(1, 77, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q.pop_back());
    model_reset();
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_in_ready", 64'(in_ready0), 64'd1);
    chk("abort_sum", 64'(out_sum0), 64'd0);
    chk("abort_count", 64'(out_count0), 64'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    cyc(1, 3, 0, 0);
    cyc(0, 0, 0, 1);
    finish_resolve(0, s0, c0, s1, c1);
    chk("after_abort_sum", 64'(s0), 64'd3);
    chk("after_abort_sum1", 64'(s1), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
